axi_uncached_store_responder: RTL and testbench

AXI4+ATOP responder (subordinate) for a small memory-mapped scratch register bank in the uncached, non-idempotent address space of the CVA6 cluster. It terminates the core's uncached single-beat stores and loads, keeping up to 7 stores outstanding plus one in flight. It returns in-order B responses and registered R responses, and rejects bursts and atomics with well-defined error responses. It sits behind the SoC crossbar on a peripheral port, after the ID-width adaptation from core to crossbar.

---
 rtl/axi_uncached_store_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_uncached_store_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_uncached_store_responder.sv
// Uncached AXI4+ATOP scratch-register responder: single-beat stores and loads,
// in-order buffered B responses, one registered R slot, error replies for bursts and atomics.
module axi_uncached_store_responder #(
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned DataWidth   = 64,
  parameter logic [63:0] BaseAddr    = 64'h1A10_0000,
  parameter int unsigned NumWords    = 16,
  parameter int unsigned BQueueDepth = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          aw_valid,
  output logic                          aw_ready,
  input  logic [IdWidth-1:0]            aw_id,
  input  logic [AddrWidth-1:0]          aw_addr,
  input  logic [7:0]                    aw_len,
  input  logic [5:0]                    aw_atop,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [DataWidth-1:0]          w_data,
  input  logic [DataWidth/8-1:0]        w_strb,
  input  logic                          w_last,
  output logic                          b_valid,
  input  logic                          b_ready,
  output logic [IdWidth-1:0]            b_id,
  output logic [1:0]                    b_resp,
  input  logic                          ar_valid,
  output logic                          ar_ready,
  input  logic [IdWidth-1:0]            ar_id,
  input  logic [AddrWidth-1:0]          ar_addr,
  input  logic [7:0]                    ar_len,
  output logic                          r_valid,
  input  logic                          r_ready,
  output logic [IdWidth-1:0]            r_id,
  output logic [DataWidth-1:0]          r_data,
  output logic [1:0]                    r_resp,
  output logic                          r_last,
  output logic [NumWords*DataWidth-1:0] words_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned PtrW = $clog2(BQueueDepth);
  localparam int unsigned CntW = $clog2(BQueueDepth + 1);
  localparam logic [AddrWidth-1:0] Base       = AddrWidth'(BaseAddr);
  localparam logic [AddrWidth-1:0] RangeBytes = AddrWidth'(NumWords * 8);
  localparam logic [PtrW-1:0]      LastPtr    = PtrW'(BQueueDepth - 1);
  localparam logic [CntW-1:0]      DepthCnt   = CntW'(BQueueDepth);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  if (DataWidth != 64) begin : gen_err_data_width
    $error("DataWidth must be 64");
  end
  if (NumWords < 2 || NumWords > 256 || (NumWords & (NumWords - 1)) != 0) begin : gen_err_num_words
    $error("NumWords must be a power of 2 between 2 and 256");
  end
  if (BQueueDepth < 8) begin : gen_err_b_depth
    $error("BQueueDepth must be at least 8");
  end

  typedef enum logic [0:0] {W_IDLE, W_DATA} wr_state_e;
  wr_state_e state_q, state_d;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [IdWidth-1:0]   wr_id_q;
  logic [7:0]           wr_len_q, beat_q;
  logic                 wr_in_range_q;
  logic [5:0]           wr_atop_q;
  logic [IdxW-1:0]      wr_idx_q;
  logic [1:0]           wr_resp;
  logic [IdWidth-1:0]   fifo_id_q [BQueueDepth];
  logic [1:0]           fifo_resp_q [BQueueDepth];
  logic [PtrW-1:0]      b_wptr_q, b_rptr_q;
  logic [CntW-1:0]      b_count_q;
  logic                 atop_r_valid_q;
  logic [IdWidth-1:0]   atop_r_id_q;
  logic [7:0]           r_beats_q;
  logic                 aw_hs, w_hs, last_beat, b_push, b_pop, ar_hs, slot_free, atop_move;
  logic [AddrWidth-1:0] aw_offset, ar_offset;
  logic                 aw_in_range, ar_in_range;
  logic                 unused_w_last;

  assign unused_w_last = w_last;
  assign aw_offset     = aw_addr - Base;
  assign ar_offset     = ar_addr - Base;
  assign aw_in_range   = aw_offset < RangeBytes;
  assign ar_in_range   = ar_offset < RangeBytes;

  assign aw_hs     = aw_valid && aw_ready;
  assign w_hs      = w_valid && w_ready;
  assign last_beat = w_hs && (beat_q == wr_len_q);
  assign b_push    = last_beat;
  assign b_pop     = b_valid && b_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= W_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:  if (aw_hs) state_d = W_DATA;
      W_DATA:  if (last_beat) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Occupancy only changes on the clock, so aw_ready never follows b_ready combinationally.
  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    case (state_q)
      W_IDLE:  aw_ready = (b_count_q < DepthCnt) && (!aw_atop[5] || !atop_r_valid_q);
      W_DATA:  w_ready = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    if (wr_atop_q != 6'd0)  wr_resp = RespSlvErr;
    else if (wr_len_q != 8'd0) wr_resp = RespSlvErr;
    else if (!wr_in_range_q)   wr_resp = RespDecErr;
    else                       wr_resp = RespOkay;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_id_q       <= '0;
      wr_len_q      <= '0;
      beat_q        <= '0;
      wr_in_range_q <= 1'b0;
      wr_atop_q     <= '0;
      wr_idx_q      <= '0;
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else begin
      if (aw_hs) begin
        wr_id_q       <= aw_id;
        wr_len_q      <= aw_len;
        beat_q        <= '0;
        wr_in_range_q <= aw_in_range;
        wr_atop_q     <= aw_atop;
        wr_idx_q      <= aw_offset[IdxW+2:3];
      end else if (w_hs) begin
        beat_q <= beat_q + 8'd1;
      end
      if (w_hs && wr_resp == RespOkay) begin
        for (int b = 0; b < DataWidth / 8; b++)
          if (w_strb[b]) mem_q[wr_idx_q][b*8 +: 8] <= w_data[b*8 +: 8];
      end
    end
  end

  assign b_valid = (b_count_q != '0);
  assign b_id    = fifo_id_q[b_rptr_q];
  assign b_resp  = fifo_resp_q[b_rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_wptr_q  <= '0;
      b_rptr_q  <= '0;
      b_count_q <= '0;
      for (int i = 0; i < BQueueDepth; i++) begin
        fifo_id_q[i]   <= '0;
        fifo_resp_q[i] <= '0;
      end
    end else begin
      if (b_push) begin
        fifo_id_q[b_wptr_q]   <= wr_id_q;
        fifo_resp_q[b_wptr_q] <= wr_resp;
        b_wptr_q <= (b_wptr_q == LastPtr) ? '0 : b_wptr_q + 1'b1;
      end
      if (b_pop) b_rptr_q <= (b_rptr_q == LastPtr) ? '0 : b_rptr_q + 1'b1;
      case ({b_push, b_pop})
        2'b10:   b_count_q <= b_count_q + 1'b1;
        2'b01:   b_count_q <= b_count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // A pending atomic read reply claims the free slot ahead of any new AR.
  assign slot_free = !r_valid || (r_ready && r_beats_q == 8'd0);
  assign atop_move = slot_free && atop_r_valid_q;
  assign ar_ready  = slot_free && !atop_r_valid_q;
  assign ar_hs     = ar_valid && ar_ready;
  assign r_last    = (r_beats_q == 8'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      atop_r_valid_q <= 1'b0;
      atop_r_id_q    <= '0;
      r_valid        <= 1'b0;
      r_id           <= '0;
      r_data         <= '0;
      r_resp         <= RespOkay;
      r_beats_q      <= '0;
    end else begin
      if (last_beat && wr_atop_q[5]) begin
        atop_r_valid_q <= 1'b1;
        atop_r_id_q    <= wr_id_q;
      end else if (atop_move) begin
        atop_r_valid_q <= 1'b0;
      end
      if (atop_move) begin
        r_valid   <= 1'b1;
        r_id      <= atop_r_id_q;
        r_data    <= '0;
        r_resp    <= RespSlvErr;
        r_beats_q <= '0;
      end else if (ar_hs) begin
        r_valid   <= 1'b1;
        r_id      <= ar_id;
        r_beats_q <= ar_len;
        if (ar_len != 8'd0) begin
          r_data <= '0;
          r_resp <= RespSlvErr;
        end else if (!ar_in_range) begin
          r_data <= '0;
          r_resp <= RespDecErr;
        end else begin
          r_data <= mem_q[ar_offset[IdxW+2:3]];
          r_resp <= RespOkay;
        end
      end else if (r_valid && r_ready) begin
        if (r_beats_q == 8'd0) r_valid <= 1'b0;
        else                   r_beats_q <= r_beats_q - 8'd1;
      end
    end
  end

  for (genvar i = 0; i < NumWords; i++) begin : gen_words
    assign words_o[i*DataWidth +: DataWidth] = mem_q[i];
  end

endmodule

// File: tb/tb_axi_uncached_store_responder.sv
// Directed bench for axi_uncached_store_responder; expected B/R replies are queued
// as stimulus is driven and checked by monitors when the DUT hands them over.
module tb_axi_uncached_store_responder;

  localparam logic [63:0] BASE = 64'h1A10_0000;
  localparam int NWORDS = 16;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct {logic [3:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic aw_valid = 0, aw_ready;
  logic [3:0] aw_id = '0;
  logic [63:0] aw_addr = '0;
  logic [7:0] aw_len = '0;
  logic [5:0] aw_atop = '0;
  logic w_valid = 0, w_ready, w_last = 0;
  logic [63:0] w_data = '0;
  logic [7:0] w_strb = '0;
  logic b_valid, b_ready = 1;
  logic [3:0] b_id;
  logic [1:0] b_resp;
  logic ar_valid = 0, ar_ready;
  logic [3:0] ar_id = '0;
  logic [63:0] ar_addr = '0;
  logic [7:0] ar_len = '0;
  logic r_valid, r_ready = 1, r_last;
  logic [3:0] r_id;
  logic [63:0] r_data;
  logic [1:0] r_resp;
  logic [NWORDS*64-1:0] words_o;

  int checks = 0, errors = 0;
  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  b_exp_t mon_b;
  r_exp_t mon_r;

  axi_uncached_store_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_atop(aw_atop),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_resp(r_resp),
    .r_last(r_last), .words_o(words_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic reportTimeout(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: observed=no handshake expected=handshake within bound", tag);
  endtask

  function automatic logic [63:0] word(input int i);
    return words_o[i*64 +: 64];
  endfunction

  // Each apply task starts just after a rising edge and returns just after its handshake edge.
  task automatic applyAw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [5:0] atop);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_atop = atop; aw_valid = 1;
    @(negedge clk_i);
    while (!aw_ready && n < 100) begin n++; @(negedge clk_i); end
    if (!aw_ready) reportTimeout("aw_handshake");
    @(posedge clk_i); #1;
    aw_valid = 0;
  endtask

  task automatic applyW(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1;
    @(negedge clk_i);
    while (!w_ready && n < 100) begin n++; @(negedge clk_i); end
    if (!w_ready) reportTimeout("w_handshake");
    @(posedge clk_i); #1;
    w_valid = 0;
  endtask

  task automatic applyAr(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_valid = 1;
    @(negedge clk_i);
    while (!ar_ready && n < 100) begin n++; @(negedge clk_i); end
    if (!ar_ready) reportTimeout("ar_handshake");
    @(posedge clk_i); #1;
    ar_valid = 0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin n++; @(negedge clk_i); end
    checkOutput("drain_b_queue", 64'(exp_b.size()), 0);
    checkOutput("drain_r_queue", 64'(exp_r.size()), 0);
    @(posedge clk_i); #1;
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && b_valid && b_ready) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $error("[TB] FAIL b_unexpected: observed=id %0d resp %0d expected=no response", b_id, b_resp);
      end else begin
        mon_b = exp_b.pop_front();
        checkOutput("b_id", 64'(b_id), 64'(mon_b.id));
        checkOutput("b_resp", 64'(b_resp), 64'(mon_b.resp));
      end
    end
    if (rst_ni && r_valid && r_ready) begin
      if (exp_r.size() == 0) begin
        checks++; errors++;
        $error("[TB] FAIL r_unexpected: observed=id %0d resp %0d expected=no response", r_id, r_resp);
      end else begin
        mon_r = exp_r.pop_front();
        checkOutput("r_id", 64'(r_id), 64'(mon_r.id));
        checkOutput("r_data", r_data, mon_r.data);
        checkOutput("r_resp", 64'(r_resp), 64'(mon_r.resp));
        checkOutput("r_last", 64'(r_last), 64'(mon_r.last));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int hs;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1;
    checkOutput("reset_aw_ready", 64'(aw_ready), 1);
    checkOutput("reset_ar_ready", 64'(ar_ready), 1);
    checkOutput("reset_w_ready", 64'(w_ready), 0);
    checkOutput("reset_b_valid", 64'(b_valid), 0);
    checkOutput("reset_r_valid", 64'(r_valid), 0);
    checkOutput("reset_bank", 64'(words_o == '0), 1);
    @(posedge clk_i); #1;

    $display("[TB] basic write/read");
    exp_b.push_back('{id: 3, resp: OKAY});
    applyAw(3, BASE + 64'h18, 0, 0);
    checkOutput("w_ready_after_aw", 64'(w_ready), 1);
    applyW(64'hDEAD_BEEF_0123_4567, 8'h0F, 1);
    checkOutput("b_latency", 64'(b_valid), 1);
    checkOutput("word3_strobed", word(3), 64'h0000_0000_0123_4567);
    exp_r.push_back('{id: 1, data: 64'h0000_0000_0123_4567, resp: OKAY, last: 1});
    applyAr(1, BASE + 64'h18, 0);
    checkOutput("r_latency", 64'(r_valid), 1);
    exp_b.push_back('{id: 2, resp: OKAY});
    applyAw(2, BASE + 64'h10, 0, 0);
    applyW(64'h1111_2222_3333_4444, 8'hFF, 1);
    waitDrain();
    checkOutput("word2_full", word(2), 64'h1111_2222_3333_4444);

    $display("[TB] error cases");
    exp_b.push_back('{id: 4, resp: SLVERR});
    applyAw(4, BASE + 64'h28, 3, 0);
    for (int i = 0; i < 4; i++) applyW(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, i == 3);
    exp_b.push_back('{id: 6, resp: DECERR});
    applyAw(6, BASE + NWORDS * 8, 0, 0);
    applyW(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1);
    for (int i = 0; i < 3; i++) exp_r.push_back('{id: 7, data: 0, resp: SLVERR, last: i == 2});
    applyAr(7, BASE, 2);
    exp_r.push_back('{id: 8, data: 0, resp: DECERR, last: 1});
    applyAr(8, BASE + NWORDS * 8, 0);
    exp_r.push_back('{id: 9, data: 0, resp: DECERR, last: 1});
    applyAr(9, BASE - 8, 0);
    exp_r.push_back('{id: 10, data: 0, resp: OKAY, last: 1});
    applyAr(10, BASE + (NWORDS - 1) * 8, 0);
    waitDrain();
    checkOutput("burst_no_write", word(5), 0);
    checkOutput("decerr_no_write", word(0), 0);

    $display("[TB] outstanding stores");
    b_ready = 0;
    for (int i = 0; i < 8; i++) begin
      exp_b.push_back('{id: 4'(i), resp: OKAY});
      applyAw(4'(i), BASE + 64'h40 + 64'(i * 8), 0, 0);
      applyW(64'hA0 + 64'(i), 8'hFF, 1);
    end
    aw_id = 8; aw_addr = BASE; aw_len = 0; aw_atop = 0; aw_valid = 1;
    hs = 0;
    repeat (4) begin @(negedge clk_i); if (aw_ready) hs++; end
    checkOutput("ninth_aw_blocked", 64'(hs), 0);
    @(posedge clk_i); #1 b_ready = 1;
    @(negedge clk_i);
    checkOutput("aw_ready_pop_cycle", 64'(aw_ready), 0);
    @(negedge clk_i);
    checkOutput("aw_ready_after_pop", 64'(aw_ready), 1);
    @(posedge clk_i); #1 aw_valid = 0;
    exp_b.push_back('{id: 8, resp: OKAY});
    applyW(64'h99, 8'hFF, 1);
    waitDrain();
    checkOutput("word15_stored", word(15), 64'hA7);

    $display("[TB] atomic");
    exp_b.push_back('{id: 5, resp: SLVERR});
    exp_r.push_back('{id: 5, data: 0, resp: SLVERR, last: 1});
    applyAw(5, BASE + 64'h20, 0, 6'h21);
    applyW(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1);
    checkOutput("ar_blocked_by_atop", 64'(ar_ready), 0);
    exp_r.push_back('{id: 6, data: 64'h0000_0000_0123_4567, resp: OKAY, last: 1});
    applyAr(6, BASE + 64'h18, 0);
    waitDrain();
    checkOutput("atomic_no_write", word(4), 0);

    $display("[TB] same-cycle hazard");
    exp_b.push_back('{id: 1, resp: OKAY});
    applyAw(1, BASE + 64'h10, 0, 0);
    exp_r.push_back('{id: 2, data: 64'h1111_2222_3333_4444, resp: OKAY, last: 1});
    w_data = 64'h5555_6666_7777_8888; w_strb = 8'hFF; w_last = 1; w_valid = 1;
    ar_id = 2; ar_addr = BASE + 64'h10; ar_len = 0; ar_valid = 1;
    @(negedge clk_i);
    checkOutput("hazard_both_ready", 64'({w_ready, ar_ready}), 64'h3);
    @(posedge clk_i); #1;
    w_valid = 0; ar_valid = 0;
    waitDrain();
    checkOutput("hazard_new_value", word(2), 64'h5555_6666_7777_8888);

    $display("[TB] reset mid-operation");
    b_ready = 0; r_ready = 0;
    applyAw(9, BASE, 0, 0);
    applyW(64'h1234, 8'hFF, 1);
    applyAr(3, BASE + 64'h10, 0);
    checkOutput("b_pending", 64'(b_valid), 1);
    checkOutput("r_pending", 64'(r_valid), 1);
    #2 rst_ni = 0;
    #1;
    checkOutput("rst_b_valid", 64'(b_valid), 0);
    checkOutput("rst_r_valid", 64'(r_valid), 0);
    checkOutput("rst_bank", 64'(words_o == '0), 1);
    @(posedge clk_i); #1 rst_ni = 1;
    b_ready = 1; r_ready = 1;
    checkOutput("post_rst_aw_ready", 64'(aw_ready), 1);
    checkOutput("post_rst_ar_ready", 64'(ar_ready), 1);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("post_rst_b_quiet", 64'(b_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
